imem_sample_buffer: RTL and testbench

- Upstream feeder for the 64-tap alu_mac stage.
- Accepts a stream of 16-bit input samples over a valid/ready handshake and holds the most recent DEPTH samples in a circular delay line (IMEM).
- After each accepted sample, issues a one-cycle start pulse to the MAC and serves tap reads (newest-first) while the MAC runs.
- Blocks new input until the MAC reports done, or until a watchdog timeout expires.

---
 rtl/imem_sample_buffer_if.sv | 26 ++
 rtl/imem_sample_buffer.sv | 100 ++++++++++
 tb/tb_imem_sample_buffer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_sample_buffer_if.sv
// Sample-in / MAC-control / tap-read bus
// for the IMEM sample buffer.
interface imem_sample_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              mac_start;
  logic              mac_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   fill_cnt;
  logic              timeout_err;

  modport master (
    output in_valid, in_data, mac_done, rd_addr,
    input  in_ready, mac_start, rd_data, fill_cnt, timeout_err
  );

  modport slave (
    input  in_valid, in_data, mac_done, rd_addr,
    output in_ready, mac_start, rd_data, fill_cnt, timeout_err
  );
endinterface

// File: rtl/imem_sample_buffer.sv
// Circular sample delay line feeding the
// alu_mac stage, with start/done/watchdog FSM.
module imem_sample_buffer #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic reset,
  imem_sample_buffer_if.slave bus
);
  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } state_t;

  state_t            state_q;
  logic              in_ready_q;
  logic              mac_start_q;
  logic              timeout_err_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   fill_q;
  logic [WD_W-1:0]   wd_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              accept;
  logic [ADDR_W-1:0] raddr_d;

  // ready is forced low while reset is held
  assign bus.in_ready    = in_ready_q & ~reset;
  assign accept          = bus.in_valid & bus.in_ready;
  assign raddr_d         = wr_ptr_q - ADDR_W'(1) - bus.rd_addr;
  assign bus.mac_start   = mac_start_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.fill_cnt    = fill_q;
  assign bus.timeout_err = timeout_err_q;

  // control FSM: accept, start pulse, wait for done or watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b1;
      mac_start_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      wr_ptr_q      <= '0;
      fill_q        <= '0;
      wd_q          <= '0;
    end else begin
      mac_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            wr_ptr_q    <= wr_ptr_q + ADDR_W'(1);
            if (fill_q != (ADDR_W+1)'(DEPTH))
              fill_q    <= fill_q + (ADDR_W+1)'(1);
            in_ready_q  <= 1'b0;
            mac_start_q <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
          wd_q    <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          wd_q <= wd_q + WD_W'(1);
          if (bus.mac_done) begin
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end else if (wd_q == WD_W'(TIMEOUT-1)) begin
            timeout_err_q <= 1'b1;
            in_ready_q    <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: begin
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  // delay line write and registered newest-first tap read
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (accept)
        mem_q[wr_ptr_q] <= bus.in_data;
      rd_data_q <= mem_q[raddr_d];
    end
  end
endmodule

// File: tb/tb_imem_sample_buffer.sv
// Directed self-checking bench for
// imem_sample_buffer.
module tb_imem_sample_buffer;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   starts = 0;
  int   s0;

  imem_sample_buffer_if #(.DATA_W(16), .ADDR_W(6)) bus ();

  imem_sample_buffer #(
    .DATA_W(16), .DEPTH(64), .ADDR_W(6), .TIMEOUT(256)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.mac_start === 1'b1) starts++;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic rd(input int a,
                    input logic [15:0] exp,
                    input string tag);
    bus.rd_addr = 6'(a);
    step();
    check(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic push(input logic [15:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("ready_at_accept", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    check("start_pulse", 32'(bus.mac_start), 1);
  endtask

  task automatic finish_mac(input int lat);
    step();
    check("start_one_cycle", 32'(bus.mac_start), 0);
    for (int i = 1; i < lat; i++) begin
      check("busy_not_ready", 32'(bus.in_ready), 0);
      step();
    end
    bus.mac_done = 1'b1;
    step();
    bus.mac_done = 1'b0;
    check("ready_after_done", 32'(bus.in_ready), 1);
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.mac_done = 1'b0;
    bus.rd_addr  = '0;

    // reset then idle
    step();
    check("rst_ready_c0", 32'(bus.in_ready), 0);
    step();
    check("rst_ready_c1", 32'(bus.in_ready), 0);
    reset = 1'b0;
    #1;
    check("ready_post_rst", 32'(bus.in_ready), 1);
    check("fill_rst", 32'(bus.fill_cnt), 0);
    check("terr_rst", 32'(bus.timeout_err), 0);
    check("start_rst", 32'(bus.mac_start), 0);
    for (int a = 0; a < 64; a++)
      rd(a, 16'h0000, "rd_zero_rst");
    check("no_start_rst", starts, 0);

    // single sample, done 5 cycles after start
    push(16'h1234);
    check("not_ready_start", 32'(bus.in_ready), 0);
    finish_mac(5);
    check("one_start", starts, 1);
    rd(0, 16'h1234, "single_k0");
    rd(1, 16'h0000, "single_k1");
    check("single_fill", 32'(bus.fill_cnt), 1);

    // wrap and ordering
    for (int i = 1; i <= 70; i++) begin
      push(16'(i));
      finish_mac(2);
      if (i == 62) check("fill_63", 32'(bus.fill_cnt), 63);
      if (i == 63) check("fill_64", 32'(bus.fill_cnt), 64);
    end
    check("fill_sat", 32'(bus.fill_cnt), 64);
    rd(0, 16'd70, "wrap_k0");
    rd(63, 16'd7, "wrap_k63");
    rd(5, 16'd65, "wrap_k5");

    // backpressure: in_valid held across busy MAC
    s0 = starts;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hAAAA;
    check("bp_ready_a", 32'(bus.in_ready), 1);
    step();
    bus.in_data = 16'hBBBB;
    check("bp_busy_start", 32'(bus.in_ready), 0);
    step();
    check("bp_busy_wait", 32'(bus.in_ready), 0);
    bus.mac_done = 1'b1;
    step();
    bus.mac_done = 1'b0;
    check("bp_ready_b", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    check("bp_start_b", 32'(bus.mac_start), 1);
    step();
    bus.mac_done = 1'b1;
    step();
    bus.mac_done = 1'b0;
    check("bp_two_starts", starts - s0, 2);
    rd(0, 16'hBBBB, "bp_k0");
    rd(1, 16'hAAAA, "bp_k1");
    rd(2, 16'd70, "bp_k2");

    // watchdog timeout
    push(16'h0001);
    step();
    for (int i = 1; i < 256; i++) step();
    check("to_not_yet", 32'(bus.timeout_err), 0);
    check("to_still_busy", 32'(bus.in_ready), 0);
    step();
    check("to_set", 32'(bus.timeout_err), 1);
    check("to_idle", 32'(bus.in_ready), 1);
    push(16'h0002);
    finish_mac(3);
    rd(0, 16'h0002, "to_next_k0");
    rd(1, 16'h0001, "to_next_k1");
    check("to_sticky", 32'(bus.timeout_err), 1);

    // reset while in WAIT
    push(16'h0009);
    step();
    step();
    step();
    s0 = starts;
    reset = 1'b1;
    step();
    check("rw_ready", 32'(bus.in_ready), 0);
    check("rw_start", 32'(bus.mac_start), 0);
    check("rw_fill", 32'(bus.fill_cnt), 0);
    check("rw_rdata", 32'(bus.rd_data), 0);
    check("rw_terr", 32'(bus.timeout_err), 0);
    reset = 1'b0;
    #1;
    check("rw_ready_post", 32'(bus.in_ready), 1);
    rd(0, 16'h0000, "rw_k0");
    rd(63, 16'h0000, "rw_k63");
    step();
    check("rw_no_start", starts - s0, 0);

    // mac_done on the timeout cycle
    push(16'h0005);
    step();
    for (int i = 1; i < 256; i++) step();
    check("co_busy", 32'(bus.in_ready), 0);
    bus.mac_done = 1'b1;
    step();
    bus.mac_done = 1'b0;
    check("co_idle", 32'(bus.in_ready), 1);
    check("co_terr", 32'(bus.timeout_err), 0);
    rd(0, 16'h0005, "co_k0");
    check("co_fill", 32'(bus.fill_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
